// File: rtl/bp_fe_pkg.sv
// bp_fe_pkg: grant-source enum and declare macro for the predictor update record
`ifndef BP_FE_PKG_SV
`define BP_FE_PKG_SV
`define DECLARE_BP_FE_PRED_UPD_S(idx_w, data_w) \
  typedef struct packed { \
    logic v; \
    logic [idx_w-1:0] idx; \
    logic [data_w-1:0] data; \
  } bp_fe_pred_upd_s
package bp_fe_pkg;
  typedef enum logic [2:0] {
    e_grant_none,
    e_grant_redirect,
    e_grant_force,
    e_grant_read,
    e_grant_attaboy
  } bp_fe_grant_e;
endpackage
`endif

// File: rtl/bp_fe_pred_port_sched_if.sv
// bp_fe_pred_port_sched_if: requester handshakes and RAM-port signals of the predictor port scheduler
interface bp_fe_pred_port_sched_if #(
  parameter int idx_width_p  = 9,
  parameter int data_width_p = 2,
  parameter int els_p        = 4
);
  logic                         r_v_i;
  logic [idx_width_p-1:0]       r_idx_i;
  logic                         r_stall_o;
  logic                         redirect_v_i;
  logic [idx_width_p-1:0]       redirect_idx_i;
  logic [data_width_p-1:0]      redirect_data_i;
  logic                         attaboy_v_i;
  logic [idx_width_p-1:0]       attaboy_idx_i;
  logic [data_width_p-1:0]      attaboy_data_i;
  logic                         attaboy_yumi_o;
  logic                         port_v_o;
  logic                         port_w_o;
  logic [idx_width_p-1:0]       port_idx_o;
  logic [data_width_p-1:0]      port_data_o;
  logic [$clog2(els_p+1)-1:0]   queue_cnt_o;
  modport master (
    output r_v_i, r_idx_i, redirect_v_i, redirect_idx_i, redirect_data_i,
           attaboy_v_i, attaboy_idx_i, attaboy_data_i,
    input  r_stall_o, attaboy_yumi_o, port_v_o, port_w_o, port_idx_o, port_data_o, queue_cnt_o
  );
  modport slave (
    input  r_v_i, r_idx_i, redirect_v_i, redirect_idx_i, redirect_data_i,
           attaboy_v_i, attaboy_idx_i, attaboy_data_i,
    output r_stall_o, attaboy_yumi_o, port_v_o, port_w_o, port_idx_o, port_data_o, queue_cnt_o
  );
endinterface

// File: rtl/bp_fe_pred_upd_queue.sv
// bp_fe_pred_upd_queue: circular attaboy queue with broadcast squash-by-index and head invalid-skip
module bp_fe_pred_upd_queue #(
  parameter int idx_width_p  = 9,
  parameter int data_width_p = 2,
  parameter int els_p        = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       enq_i,
  input  logic [idx_width_p-1:0]     enq_idx_i,
  input  logic [data_width_p-1:0]    enq_data_i,
  input  logic                       deq_i,
  input  logic                       squash_v_i,
  input  logic [idx_width_p-1:0]     squash_idx_i,
  output logic                       head_v_o,
  output logic [idx_width_p-1:0]     head_idx_o,
  output logic [data_width_p-1:0]    head_data_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(els_p+1)-1:0] cnt_o
);
  `DECLARE_BP_FE_PRED_UPD_S(idx_width_p, data_width_p);
  localparam int pw = $clog2(els_p);
  localparam int cw = $clog2(els_p+1);
  bp_fe_pred_upd_s mem [els_p];
  logic [pw-1:0] head, tail;
  logic [cw-1:0] cnt;
  logic pop;
  assign empty_o     = cnt == '0;
  assign full_o      = cnt == cw'(els_p);
  assign head_v_o    = ~empty_o & mem[head].v;
  assign head_idx_o  = mem[head].idx;
  assign head_data_o = mem[head].data;
  assign cnt_o       = cnt;
  // a squashed head leaves without a grant, one entry per cycle
  assign pop = deq_i | (~empty_o & ~mem[head].v);
  // pointers wrap naturally since depth is a power of two
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head + pw'(pop);
      tail <= tail + pw'(enq_i);
      cnt  <= cnt + cw'(enq_i) - cw'(pop);
    end
  // squash older matches; the entry written this cycle is younger and survives
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < els_p; i++)
      if (squash_v_i && mem[i].idx == squash_idx_i) mem[i].v <= 1'b0;
    if (enq_i) mem[tail] <= '{v: 1'b1, idx: enq_idx_i, data: enq_data_i};
  end
endmodule

// File: rtl/bp_fe_pred_port_sched.sv
// bp_fe_pred_port_sched: 1RW predictor port arbiter; BP_FE_PRED_SCHED_BYPASS_EN enables same-cycle attaboy writes
module bp_fe_pred_port_sched
  import bp_fe_pkg::*;
#(
  parameter int idx_width_p    = 9,
  parameter int data_width_p   = 2,
  parameter int els_p          = 4,
  parameter int starve_limit_p = 8
) (
  input logic clk_i,
  input logic reset_n_i,
  bp_fe_pred_port_sched_if.slave bus
);
  localparam int sw = $clog2(starve_limit_p+1);
  logic [sw-1:0] starve;
  logic [idx_width_p-1:0] head_idx;
  logic [data_width_p-1:0] head_data;
  logic head_v, empty, full, bypass, sat, head_grant, enq;
  bp_fe_grant_e grant;
`ifdef BP_FE_PRED_SCHED_BYPASS_EN
  assign bypass = empty & ~bus.redirect_v_i & ~bus.r_v_i & bus.attaboy_v_i;
`else
  assign bypass = 1'b0;
`endif
  assign sat = starve == sw'(starve_limit_p);
  assign bus.attaboy_yumi_o = bus.attaboy_v_i & ~full;
  assign enq = bus.attaboy_yumi_o & ~bypass;
  bp_fe_pred_upd_queue #(
    .idx_width_p(idx_width_p), .data_width_p(data_width_p), .els_p(els_p)
  ) queue (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .enq_i(enq), .enq_idx_i(bus.attaboy_idx_i), .enq_data_i(bus.attaboy_data_i),
    .deq_i(head_grant),
    .squash_v_i(bus.redirect_v_i), .squash_idx_i(bus.redirect_idx_i),
    .head_v_o(head_v), .head_idx_o(head_idx), .head_data_o(head_data),
    .empty_o(empty), .full_o(full), .cnt_o(bus.queue_cnt_o)
  );
  // fixed-priority grant and port mux
  always_comb begin
    grant = bus.redirect_v_i ? e_grant_redirect
          : (head_v && sat)  ? e_grant_force
          : bus.r_v_i        ? e_grant_read
          : (head_v || bypass) ? e_grant_attaboy
          : e_grant_none;
    head_grant      = grant == e_grant_force || (grant == e_grant_attaboy && head_v);
    bus.port_v_o    = grant != e_grant_none;
    bus.port_w_o    = bus.port_v_o && grant != e_grant_read;
    bus.port_idx_o  = grant == e_grant_redirect ? bus.redirect_idx_i
                    : grant == e_grant_read     ? bus.r_idx_i
                    : bypass                    ? bus.attaboy_idx_i
                    : head_idx;
    bus.port_data_o = grant == e_grant_redirect ? bus.redirect_data_i
                    : bypass                    ? bus.attaboy_data_i
                    : head_data;
    bus.r_stall_o   = bus.r_v_i && (grant == e_grant_redirect || grant == e_grant_force);
  end
  // starvation counter: counts cycles a waiting head is passed over, saturating
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) starve <= '0;
    else starve <= (empty || head_grant) ? '0 : sat ? starve : starve + sw'(1);
endmodule

// File: tb/tb_bp_fe_pred_port_sched.sv
// tb_bp_fe_pred_port_sched: vector table, corner sequences and a randomized run against a queue-level model
module tb_bp_fe_pred_port_sched;
  localparam int LEN = 4;
  localparam int LIM = 8;
`ifdef BP_FE_PRED_SCHED_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct {
    logic r_v; logic [8:0] r_idx;
    logic red_v; logic [8:0] red_idx; logic [1:0] red_data;
    logic ab_v; logic [8:0] ab_idx; logic [1:0] ab_data;
  } in_t;
  typedef struct {
    in_t in;
    logic pv, pw; logic [8:0] pidx; logic [1:0] pdata;
    logic stall, yumi; logic [2:0] cnt;
  } vec_t;
  typedef struct { logic [8:0] idx; logic [1:0] data; bit v; } ent_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  ent_t mq[$];
  int mst = 0;
  int mg = 0;
  bit mbyp = 1'b0;

  bp_fe_pred_port_sched_if #(.idx_width_p(9), .data_width_p(2), .els_p(LEN)) bus ();
  bp_fe_pred_port_sched #(.idx_width_p(9), .data_width_p(2), .els_p(LEN), .starve_limit_p(LIM))
    dut (.clk_i(clk), .reset_n_i(reset_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
  endtask

  function automatic in_t mi(bit rv, int ri, bit dv, int di, int dd, bit av, int ai, int ad);
    in_t x;
    x.r_v = rv; x.r_idx = 9'(ri);
    x.red_v = dv; x.red_idx = 9'(di); x.red_data = 2'(dd);
    x.ab_v = av; x.ab_idx = 9'(ai); x.ab_data = 2'(ad);
    return x;
  endfunction

  // expected behaviour straight from the priority rules over a queue of records
  task automatic model_cmp();
    bit hok, frc;
    logic [8:0] ei;
    logic [1:0] ed;
    hok = mq.size() > 0 && mq[0].v;
    frc = hok && mst == LIM && !bus.redirect_v_i;
    mbyp = BYP && mq.size() == 0 && !bus.redirect_v_i && !bus.r_v_i && bus.attaboy_v_i;
    ei = '0; ed = '0;
    if (bus.redirect_v_i) begin mg = 1; ei = bus.redirect_idx_i; ed = bus.redirect_data_i; end
    else if (frc || (!bus.r_v_i && hok)) begin mg = 2; ei = mq[0].idx; ed = mq[0].data; end
    else if (bus.r_v_i) begin mg = 3; ei = bus.r_idx_i; end
    else if (mbyp) begin mg = 4; ei = bus.attaboy_idx_i; ed = bus.attaboy_data_i; end
    else mg = 0;
    chk("m_port_v", 32'(bus.port_v_o), 32'(mg != 0));
    chk("m_port_w", 32'(bus.port_w_o), 32'(mg == 1 || mg == 2 || mg == 4));
    if (mg != 0) chk("m_port_idx", 32'(bus.port_idx_o), 32'(ei));
    if (mg != 0 && mg != 3) chk("m_port_data", 32'(bus.port_data_o), 32'(ed));
    chk("m_r_stall", 32'(bus.r_stall_o), 32'(bus.r_v_i && (mg == 1 || frc)));
    chk("m_yumi", 32'(bus.attaboy_yumi_o), 32'(bus.attaboy_v_i && mq.size() < LEN));
    chk("m_qcnt", 32'(bus.queue_cnt_o), 32'(mq.size()));
  endtask

  task automatic model_upd();
    bit disc, was_empty, acc;
    ent_t e;
    was_empty = mq.size() == 0;
    disc = !was_empty && !mq[0].v;
    acc = bus.attaboy_v_i && mq.size() < LEN && !mbyp;
    if (bus.redirect_v_i)
      foreach (mq[i]) if (mq[i].idx == bus.redirect_idx_i) mq[i].v = 1'b0;
    if (mg == 2 || disc) void'(mq.pop_front());
    if (acc) begin
      e.idx = bus.attaboy_idx_i; e.data = bus.attaboy_data_i; e.v = 1'b1;
      mq.push_back(e);
    end
    mst = (was_empty || mg == 2) ? 0 : (mst < LIM ? mst + 1 : LIM);
  endtask

  task automatic apply(input in_t x);
    bus.r_v_i = x.r_v; bus.r_idx_i = x.r_idx;
    bus.redirect_v_i = x.red_v; bus.redirect_idx_i = x.red_idx; bus.redirect_data_i = x.red_data;
    bus.attaboy_v_i = x.ab_v; bus.attaboy_idx_i = x.ab_idx; bus.attaboy_data_i = x.ab_data;
    #1;
    model_cmp();
  endtask

  task automatic adv();
    @(posedge clk);
    model_upd();
    @(negedge clk);
  endtask

  vec_t tbl[15];
  in_t idle, rd;

  initial begin
    idle = mi(0, 0, 0, 0, 0, 0, 0, 0);
    rd = mi(1, 'h10, 0, 0, 0, 0, 0, 0);
    tbl[0]  = '{idle,                               0, 0, 9'h00, 2'd0, 0, 0, 3'd0};
    tbl[1]  = '{rd,                                 1, 0, 9'h10, 2'd0, 0, 0, 3'd0};
    tbl[2]  = '{mi(1, 'h10, 1, 'h33, 1, 0, 0, 0),   1, 1, 9'h33, 2'd1, 1, 0, 3'd0};
    tbl[3]  = '{mi(1, 'h10, 0, 0, 0, 1, 'h20, 2),   1, 0, 9'h10, 2'd0, 0, 1, 3'd0};
    tbl[4]  = '{idle,                               1, 1, 9'h20, 2'd2, 0, 0, 3'd1};
    tbl[5]  = '{idle,                               0, 0, 9'h00, 2'd0, 0, 0, 3'd0};
    tbl[6]  = '{mi(0, 0, 1, 'h44, 3, 0, 0, 0),      1, 1, 9'h44, 2'd3, 0, 0, 3'd0};
    tbl[7]  = '{mi(1, 'h11, 0, 0, 0, 1, 'h05, 1),   1, 0, 9'h11, 2'd0, 0, 1, 3'd0};
    tbl[8]  = '{mi(1, 'h11, 0, 0, 0, 1, 'h07, 2),   1, 0, 9'h11, 2'd0, 0, 1, 3'd1};
    tbl[9]  = '{mi(1, 'h11, 0, 0, 0, 1, 'h05, 0),   1, 0, 9'h11, 2'd0, 0, 1, 3'd2};
    tbl[10] = '{mi(1, 'h11, 1, 'h05, 3, 0, 0, 0),   1, 1, 9'h05, 2'd3, 1, 0, 3'd3};
    tbl[11] = '{idle,                               0, 0, 9'h00, 2'd0, 0, 0, 3'd3};
    tbl[12] = '{idle,                               1, 1, 9'h07, 2'd2, 0, 0, 3'd2};
    tbl[13] = '{idle,                               0, 0, 9'h00, 2'd0, 0, 0, 3'd1};
    tbl[14] = '{idle,                               0, 0, 9'h00, 2'd0, 0, 0, 3'd0};

    apply(idle);
    chk("rst_port_v", 32'(bus.port_v_o), 0);
    chk("rst_qcnt", 32'(bus.queue_cnt_o), 0);
    chk("rst_stall", 32'(bus.r_stall_o), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int k = 0; k < 15; k++) begin
      apply(tbl[k].in);
      chk($sformatf("t%0d_port_v", k), 32'(bus.port_v_o), 32'(tbl[k].pv));
      chk($sformatf("t%0d_port_w", k), 32'(bus.port_w_o), 32'(tbl[k].pw));
      if (tbl[k].pv) chk($sformatf("t%0d_idx", k), 32'(bus.port_idx_o), 32'(tbl[k].pidx));
      if (tbl[k].pw) chk($sformatf("t%0d_data", k), 32'(bus.port_data_o), 32'(tbl[k].pdata));
      chk($sformatf("t%0d_stall", k), 32'(bus.r_stall_o), 32'(tbl[k].stall));
      chk($sformatf("t%0d_yumi", k), 32'(bus.attaboy_yumi_o), 32'(tbl[k].yumi));
      chk($sformatf("t%0d_qcnt", k), 32'(bus.queue_cnt_o), 32'(tbl[k].cnt));
      adv();
    end

    apply(mi(1, 'h10, 0, 0, 0, 1, 'h20, 1));
    adv();
    for (int k = 1; k <= 10; k++) begin
      apply(rd);
      chk($sformatf("starve%0d_w", k), 32'(bus.port_w_o), 32'(k == 9));
      chk($sformatf("starve%0d_idx", k), 32'(bus.port_idx_o), k == 9 ? 32'h20 : 32'h10);
      chk($sformatf("starve%0d_stall", k), 32'(bus.r_stall_o), 32'(k == 9));
      adv();
    end

    for (int k = 0; k < 4; k++) begin
      apply(mi(1, 'h10, 0, 0, 0, 1, 'h21 + k, k));
      chk("fill_yumi", 32'(bus.attaboy_yumi_o), 1);
      adv();
    end
    for (int c = 0; c <= 6; c++) begin
      apply(mi(1, 'h10, 0, 0, 0, 1, 'h25, 3));
      if (c == 0) chk("full_qcnt", 32'(bus.queue_cnt_o), 4);
      chk($sformatf("full%0d_yumi", c), 32'(bus.attaboy_yumi_o), 32'(c == 6));
      chk($sformatf("full%0d_forced", c), 32'(bus.port_w_o), 32'(c == 5));
      adv();
    end
    for (int k = 0; k < 20 && bus.queue_cnt_o != 0; k++) begin
      apply(idle);
      adv();
    end
    chk("drain_qcnt", 32'(bus.queue_cnt_o), 0);

    apply(mi(1, 'h10, 0, 0, 0, 1, 'h30, 2));
    adv();
    repeat (LIM) begin
      apply(rd);
      adv();
    end
    apply(mi(1, 'h10, 1, 'h31, 1, 0, 0, 0));
    chk("coll_red_idx", 32'(bus.port_idx_o), 32'h31);
    chk("coll_red_stall", 32'(bus.r_stall_o), 1);
    adv();
    apply(rd);
    chk("coll_force_idx", 32'(bus.port_idx_o), 32'h30);
    chk("coll_force_w", 32'(bus.port_w_o), 1);
    chk("coll_force_stall", 32'(bus.r_stall_o), 1);
    adv();
    apply(rd);
    chk("coll_after_w", 32'(bus.port_w_o), 0);
    adv();

    apply(mi(0, 0, 0, 0, 0, 1, 'h3, 1));
    chk("byp_yumi", 32'(bus.attaboy_yumi_o), 1);
    chk("byp_same_w", 32'(bus.port_w_o), 32'(BYP));
    if (BYP) chk("byp_same_idx", 32'(bus.port_idx_o), 32'h3);
    adv();
    apply(idle);
    chk("byp_next_qcnt", 32'(bus.queue_cnt_o), 32'(!BYP));
    chk("byp_next_w", 32'(bus.port_w_o), 32'(!BYP));
    if (!BYP) chk("byp_next_idx", 32'(bus.port_idx_o), 32'h3);
    adv();

    for (int k = 0; k < 3000; k++) begin
      in_t x;
      x.r_v = ($urandom_range(0, 1) == 1);
      x.r_idx = 9'($urandom_range(0, 7));
      x.red_v = ($urandom_range(0, 6) == 0);
      x.red_idx = 9'($urandom_range(0, 7));
      x.red_data = 2'($urandom);
      x.ab_v = ($urandom_range(0, 2) != 0);
      x.ab_idx = 9'($urandom_range(0, 7));
      x.ab_data = 2'($urandom);
      apply(x);
      adv();
    end

    for (int k = 0; k < 3; k++) begin
      apply(mi(1, 'h10, 0, 0, 0, 1, 'h50 + k, 1));
      adv();
    end
    apply(idle);
    #2 reset_n = 1'b0;
    #1;
    chk("async_port_v", 32'(bus.port_v_o), 0);
    chk("async_qcnt", 32'(bus.queue_cnt_o), 0);
    chk("async_stall", 32'(bus.r_stall_o), 0);
    chk("async_yumi", 32'(bus.attaboy_yumi_o), 0);
    mq.delete();
    mst = 0;
    @(negedge clk);
    reset_n = 1'b1;
    apply(rd);
    chk("post_rst_read", 32'(bus.port_idx_o), 32'h10);
    adv();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
